// File: rtl/tile_scheduler_pkg.sv
// Shared types and sizing for the tile scheduler: instruction word layout,
// FSM state encoding and the index width.
package tile_scheduler_pkg;

    localparam int IDX_W      = 8;
    localparam int INSTR_SIZE = 32;

    // Elaboration-time guard evaluated by the top module.
    localparam bit INSTR_FITS = (INSTR_SIZE >= 2 + 3 * IDX_W);

    // Declared MSB first: k_idx lands in the LSBs, first in the top used bit.
    typedef struct packed {
        logic             first;
        logic             last;
        logic [IDX_W-1:0] m_idx;
        logic [IDX_W-1:0] n_idx;
        logic [IDX_W-1:0] k_idx;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } sched_state_e;

    function automatic logic [INSTR_SIZE-1:0] pad_instr(instr_t i);
        pad_instr = '0;
        pad_instr[$bits(instr_t)-1:0] = i;
    endfunction

endpackage

// File: rtl/tile_scheduler_counter3.sv
// Nested k/n/m step counter: k is the innermost level, m the outermost.
// Each level wraps to zero when it is at its limit and the carry reaches it.
module tile_counter3
    import tile_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [IDX_W-1:0] m_tiles,
    input  logic [IDX_W-1:0] n_tiles,
    input  logic [IDX_W-1:0] k_tiles,
    output logic [IDX_W-1:0] m_idx,
    output logic [IDX_W-1:0] n_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             is_last_k,
    output logic             next_is_last_k,
    output logic             is_final
);

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [IDX_W-1:0] lim [3];
    logic [IDX_W-1:0] idx [3];
    logic [2:0]       at_last;

    assign lim[0] = k_tiles;
    assign lim[1] = n_tiles;
    assign lim[2] = m_tiles;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_level
            localparam logic [2:0] LOWER = 3'((1 << gi) - 1);
            logic [IDX_W-1:0] idx_reg;
            logic             carry;

            assign at_last[gi] = (idx_reg == lim[gi] - IDX_ONE);
            // A level steps only when every inner level is wrapping.
            assign carry       = inc && ((at_last & LOWER) == LOWER);
            assign idx[gi]     = idx_reg;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    idx_reg <= '0;
                end else if (carry) begin
                    idx_reg <= at_last[gi] ? '0 : idx_reg + IDX_ONE;
                end
            end
        end
    endgenerate

    assign k_idx     = idx[0];
    assign n_idx     = idx[1];
    assign m_idx     = idx[2];
    assign is_last_k = at_last[0];
    assign is_final  = &at_last;

    // last flag of the step that follows the current one
    assign next_is_last_k = is_last_k ? (k_tiles == IDX_ONE)
                                      : (idx[0] + IDX_ONE == k_tiles - IDX_ONE);

endmodule

// File: rtl/tile_scheduler.sv
// Walks an M x N x K job through the controller's instruction port, limits
// output tiles in flight and reports completion once all tiles have drained.
module tile_scheduler
    import tile_scheduler_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int OUT_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [IDX_W-1:0]      job_m_tiles,
    input  logic [IDX_W-1:0]      job_n_tiles,
    input  logic [IDX_W-1:0]      job_k_tiles,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    input  logic                  ctrl_ready,
    input  logic                  tile_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    generate
        if (!INSTR_FITS) begin : g_bad_instr_size
            $error("INSTR_SIZE cannot hold first, last and three indices");
        end
        if ((1 << OUT_W) <= MAX_OUT) begin : g_bad_out_w
            $error("OUT_W too narrow for MAX_OUT");
        end
    endgenerate

    localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
    localparam logic [OUT_W-1:0] OUT_FULL = OUT_W'(MAX_OUT);

    sched_state_e     state_reg, state_next;
    logic             instr_valid_reg, instr_valid_next;
    logic [OUT_W-1:0] outstanding_reg, outstanding_next;
    logic             err_reg, err_next;
    logic [IDX_W-1:0] m_tiles_reg, n_tiles_reg, k_tiles_reg;

    logic [IDX_W-1:0] m_idx, n_idx, k_idx;
    logic             is_last_k, next_is_last_k, is_final;
    logic             job_accept, zero_dim, step_accept, last_accept, bad_done;
    instr_t           cur_instr;

    tile_counter3 u_counter (
        .clk           (clk),
        .rst           (rst),
        .clear         (job_accept),
        .inc           (step_accept),
        .m_tiles       (m_tiles_reg),
        .n_tiles       (n_tiles_reg),
        .k_tiles       (k_tiles_reg),
        .m_idx         (m_idx),
        .n_idx         (n_idx),
        .k_idx         (k_idx),
        .is_last_k     (is_last_k),
        .next_is_last_k(next_is_last_k),
        .is_final      (is_final)
    );

    assign job_accept  = (state_reg == ST_IDLE) && job_valid;
    assign zero_dim    = (job_m_tiles == '0) || (job_n_tiles == '0) || (job_k_tiles == '0);
    assign step_accept = (state_reg == ST_ISSUE) && instr_valid_reg && ctrl_ready;
    assign last_accept = step_accept && is_last_k;
    // A drain pulse paired with a same-cycle last acceptance is a legal swap.
    assign bad_done    = tile_done && (outstanding_reg == '0) && !last_accept;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (last_accept && !tile_done) begin
            outstanding_next = outstanding_reg + OUT_ONE;
        end else if (!last_accept && tile_done && outstanding_reg != '0) begin
            outstanding_next = outstanding_reg - OUT_ONE;
        end
    end

    always_comb begin
        state_next       = state_reg;
        instr_valid_next = 1'b0;
        err_next         = (job_accept ? zero_dim : err_reg) | bad_done;
        case (state_reg)
            ST_IDLE: begin
                if (job_valid) begin
                    state_next = zero_dim ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (step_accept) begin
                    if (is_final) begin
                        state_next = ST_DRAIN;
                    end else begin
                        instr_valid_next = !(next_is_last_k && outstanding_next >= OUT_FULL);
                    end
                end else if (instr_valid_reg) begin
                    instr_valid_next = 1'b1;
                end else begin
                    instr_valid_next = !(is_last_k && outstanding_next >= OUT_FULL);
                end
            end
            ST_DRAIN: begin
                if (outstanding_reg == '0) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            instr_valid_reg <= 1'b0;
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
            m_tiles_reg     <= '0;
            n_tiles_reg     <= '0;
            k_tiles_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            instr_valid_reg <= instr_valid_next;
            outstanding_reg <= outstanding_next;
            err_reg         <= err_next;
            if (job_accept) begin
                m_tiles_reg <= job_m_tiles;
                n_tiles_reg <= job_n_tiles;
                k_tiles_reg <= job_k_tiles;
            end
        end
    end

    assign cur_instr = '{first: (k_idx == '0), last: is_last_k,
                         m_idx: m_idx, n_idx: n_idx, k_idx: k_idx};

    assign instr       = instr_valid_reg ? pad_instr(cur_instr) : '0;
    assign instr_valid = instr_valid_reg;
    assign job_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    assign done        = (state_reg == ST_FIN);
    assign err         = err_reg;

endmodule
